// File: rtl/nand_cpu_pkg.sv
// nand_cpu_pkg: widths and types shared by the store commit queue and its drain port.
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif

package nand_cpu_pkg;
    localparam int ROB_W = $clog2(`ROB_LENGTH);
    localparam int REG_W = $clog2(`NUM_D_REG);
    localparam int SQ_DATA_W = 16;

    typedef struct packed {
        logic [ROB_W-1:0]     rob_addr;
        logic [SQ_DATA_W-1:0] addr;
        logic [SQ_DATA_W-1:0] data;
    } sq_entry_t;

    typedef enum logic {IDLE, REQ} drain_state_t;
endpackage

// File: rtl/store_drain_port.sv
// store_drain_port: writes committed stores to memory one at a time over req/ack.
module store_drain_port
    import nand_cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  sq_entry_t            head_entry,
    input  logic                 pending,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic [SQ_DATA_W-1:0] mem_addr,
    output logic [SQ_DATA_W-1:0] mem_data,
    output logic                 advance
);
    drain_state_t state, state_nxt;
    logic load;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                mem_addr <= head_entry.addr;
                mem_data <= head_entry.data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        if (state == IDLE && pending) begin
            load      = 1'b1;
            state_nxt = REQ;
        end else if (state == REQ && mem_ack) begin
            advance   = 1'b1;
            state_nxt = IDLE;
        end
    end

    assign mem_req = (state == REQ);
endmodule

// File: rtl/store_commit_queue.sv
// store_commit_queue: captures ready stores, holds them until ROB commit, then drains in order.
module store_commit_queue
    import nand_cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = SQ_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sb_valid,
    input  logic [ROB_W-1:0]  sb_rob_addr,
    input  logic [REG_W-1:0]  sb_ra_addr,
    input  logic [REG_W-1:0]  sb_rt_addr,
    output logic              sb_pop,
    output logic [REG_W-1:0]  rf_ra_addr,
    output logic [REG_W-1:0]  rf_rt_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    output logic              done_valid,
    output logic [ROB_W-1:0]  done_rob_addr,
    input  logic              commit_valid,
    input  logic [ROB_W-1:0]  commit_rob_addr,
    input  logic              flush,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    sq_entry_t q [DEPTH];
    logic [PW-1:0] head, cmt, tail, cmt_nxt, count;
    logic commit_ok, advance;

    assign rf_ra_addr = sb_ra_addr;
    assign rf_rt_addr = sb_rt_addr;
    assign count      = tail - head;
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign sb_pop     = sb_valid & ~full & ~flush;
    assign commit_ok  = commit_valid & (cmt != tail) & (q[cmt[PW-2:0]].rob_addr == commit_rob_addr);
    assign cmt_nxt    = cmt + PW'(commit_ok);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head          <= '0;
            cmt           <= '0;
            tail          <= '0;
            done_valid    <= 1'b0;
            done_rob_addr <= '0;
        end else begin
            head       <= head + PW'(advance);
            cmt        <= cmt_nxt;
            tail       <= flush ? cmt_nxt : tail + PW'(sb_pop);
            done_valid <= sb_pop;
            if (sb_pop) done_rob_addr <= sb_rob_addr;
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (sb_pop) q[tail[PW-2:0]] <= '{rob_addr: sb_rob_addr, addr: rf_ra_data, data: rf_rt_data};
    end

    store_drain_port u_drain (
        .clk        (clk),
        .n_rst      (n_rst),
        .head_entry (q[head[PW-2:0]]),
        .pending    (head != cmt),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .advance    (advance)
    );
endmodule

// File: tb/tb_store_commit_queue.sv
// tb_store_commit_queue: directed and random stimulus checked against a queue-based store model.
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif

module tb_store_commit_queue;
    localparam int DEPTH = 4;
    localparam int DW = 16;
    localparam int RW = $clog2(`ROB_LENGTH);
    localparam int GW = $clog2(`NUM_D_REG);

    logic clk = 0, n_rst = 0;
    logic sb_valid = 0, commit_valid = 0, flush = 0, mem_ack = 0;
    logic [RW-1:0] sb_rob_addr = 0, commit_rob_addr = 0;
    logic [GW-1:0] sb_ra_addr = 0, sb_rt_addr = 0;
    logic [DW-1:0] rf_ra_data = 0, rf_rt_data = 0;
    logic sb_pop, done_valid, mem_req, full, empty;
    logic [GW-1:0] rf_ra_addr, rf_rt_addr;
    logic [RW-1:0] done_rob_addr;
    logic [DW-1:0] mem_addr, mem_data;

    store_commit_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .n_rst(n_rst), .sb_valid(sb_valid), .sb_rob_addr(sb_rob_addr),
        .sb_ra_addr(sb_ra_addr), .sb_rt_addr(sb_rt_addr), .sb_pop(sb_pop),
        .rf_ra_addr(rf_ra_addr), .rf_rt_addr(rf_rt_addr), .rf_ra_data(rf_ra_data),
        .rf_rt_data(rf_rt_data), .done_valid(done_valid), .done_rob_addr(done_rob_addr),
        .commit_valid(commit_valid), .commit_rob_addr(commit_rob_addr), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] rob;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } st_t;

    // Model: speculative stores, committed stores awaiting memory (front may be in flight).
    st_t spec_q[$];
    st_t com_q[$];
    bit inflight = 0, exp_done = 0;
    logic [RW-1:0] exp_tag = 0;
    int n_assert = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit exp_pop();
        return sb_valid && !flush && (spec_q.size() + com_q.size() < DEPTH);
    endfunction

    task automatic check_all();
        int n = spec_q.size() + com_q.size();
        chk("sb_pop", sb_pop, exp_pop());
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("rf_ra_addr", rf_ra_addr, sb_ra_addr);
        chk("rf_rt_addr", rf_rt_addr, sb_rt_addr);
        chk("done_valid", done_valid, exp_done);
        if (exp_done) chk("done_rob_addr", done_rob_addr, exp_tag);
        chk("mem_req", mem_req, inflight);
        if (inflight) begin
            chk("mem_addr", mem_addr, com_q[0].addr);
            chk("mem_data", mem_data, com_q[0].data);
        end
    endtask

    task automatic model_edge();
        bit pend = com_q.size() > 0;
        bit pop = exp_pop();
        if (inflight && mem_ack) begin
            void'(com_q.pop_front());
            inflight = 0;
        end else if (!inflight && pend) inflight = 1;
        if (commit_valid && spec_q.size() > 0 && spec_q[0].rob == commit_rob_addr)
            com_q.push_back(spec_q.pop_front());
        if (flush) spec_q.delete();
        if (pop) spec_q.push_back('{sb_rob_addr, rf_ra_data, rf_rt_data});
        exp_done = pop;
        if (pop) exp_tag = sb_rob_addr;
    endtask

    // One clock: drive inputs at posedge+1, check, take the edge, update the model.
    task automatic step(input logic v, input logic [RW-1:0] tag, input logic [DW-1:0] a,
                        input logic [DW-1:0] d, input logic cv, input logic [RW-1:0] ct,
                        input logic fl, input logic ack);
        sb_valid = v; sb_rob_addr = tag; rf_ra_data = a; rf_rt_data = d;
        sb_ra_addr = GW'($urandom); sb_rt_addr = GW'($urandom);
        commit_valid = cv; commit_rob_addr = ct; flush = fl; mem_ack = ack;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ack);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4 * DEPTH + 4 && !(spec_q.size() == 0 && com_q.size() == 0); i++)
            idle(1, 1);
        idle(1, 0);
        chk("drained_empty", empty, 1);
    endtask

    initial begin
        #3;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_rob_addr", done_rob_addr, 0);
        #9 n_rst = 1;
        @(posedge clk); #1;

        // First store waits for its commit before going to memory.
        step(1, 3, 16'h1234, 16'hBEEF, 0, 0, 0, 0);
        idle(3, 0);
        step(0, 0, 0, 0, 1, 3, 0, 0);
        idle(1, 0);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 16'h1234);
        chk("t1_mem_data", mem_data, 16'hBEEF);
        drain_all();

        // Fill, then commit everything while memory stalls.
        for (int i = 0; i < DEPTH; i++) step(1, RW'(i), DW'(16'h100 + i), DW'(16'h200 + i), 0, 0, 0, 0);
        step(1, 9, 16'hDEAD, 16'hDEAD, 0, 0, 0, 0);
        chk("fill_full", full, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, RW'(i), 0, 0);
        idle(3, 0);
        chk("stall_mem_addr", mem_addr, 16'h100);
        drain_all();

        // Flush in the same cycle as the last commit keeps that store.
        for (int i = 5; i < 8; i++) step(1, RW'(i), DW'(16'h500 + i), DW'(16'h600 + i), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 1, 6, 0, 0);
        step(1, 8, 16'h0BAD, 16'h0BAD, 1, 7, 1, 0);
        chk("flush_commit_done_clr", done_valid, 0);
        drain_all();

        // Flush discards the uncommitted tail and blocks the accept.
        for (int i = 1; i < 4; i++) step(1, RW'(i), DW'(16'h700 + i), DW'(16'h800 + i), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 4, 16'hF00D, 16'hF00D, 0, 0, 1, 0);
        chk("flush_empty", empty, 0);
        drain_all();

        // Asynchronous reset in the middle of a request.
        step(1, 2, 16'hAAAA, 16'h5555, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2, 0, 0);
        idle(1, 0);
        chk("pre_rst_mem_req", mem_req, 1);
        #2 n_rst = 0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_empty", empty, 1);
        chk("async_done", done_valid, 0);
        spec_q.delete(); com_q.delete(); inflight = 0; exp_done = 0;
        @(negedge clk) n_rst = 1;
        @(posedge clk); #1;
        step(1, 6, 16'h4242, 16'h2424, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6, 0, 0);
        drain_all();

        // Wrap the pointers several times.
        for (int i = 0; i < 10; i++) begin
            step(1, RW'(i), DW'($urandom), DW'($urandom), 0, 0, 0, 0);
            step(0, 0, 0, 0, 1, RW'(i), 0, 0);
            drain_all();
        end

        // A wrong tag must not commit.
        step(1, 4, 16'hC0DE, 16'hFACE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9, 0, 0);
        idle(3, 1);
        chk("wrong_tag_no_req", mem_req, 0);
        step(0, 0, 0, 0, 1, 4, 0, 0);
        drain_all();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [RW-1:0] ct = RW'($urandom);
            if (spec_q.size() > 0 && $urandom_range(0, 3) != 0) ct = spec_q[0].rob;
            step($urandom_range(0, 1), RW'($urandom), DW'($urandom), DW'($urandom),
                 $urandom_range(0, 1), ct, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end
        idle(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
